delta_tile_sched: RTL and testbench



---
 rtl/delta_tile_sched_if.sv | 36 +++
 rtl/delta_tile_sched.sv | 152 +++++++++++++++
 tb/tb_delta_tile_sched.sv | 349 ++++++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/delta_tile_sched_if.sv
// Handshake/bus bundle of the delta tile sequencer: start/status, dt/bias
// buffer read port, adder array hookup and the result write port.
interface delta_tile_sched_if #(
    parameter int DW     = 16,
    parameter int H_TILE = 4,
    parameter int AW     = 8
);
    logic                   start_i;
    logic                   busy_o;
    logic                   done_o;
    logic                   rd_en_o;
    logic [AW-1:0]          rd_addr_o;
    logic                   add_valid_o;
    logic                   add_valid_i;
    logic [H_TILE*DW-1:0]   add_sum_i;
    logic                   wr_en_o;
    logic [AW-1:0]          wr_addr_o;
    logic [H_TILE*DW-1:0]   wr_data_o;
    logic [H_TILE-1:0]      wr_mask_o;
    logic                   wr_ready_i;
    logic                   err_o;

    // Scheduler side
    modport master (
        input  start_i, add_valid_i, add_sum_i, wr_ready_i,
        output busy_o, done_o, rd_en_o, rd_addr_o, add_valid_o,
               wr_en_o, wr_addr_o, wr_data_o, wr_mask_o, err_o
    );

    // Environment side (buffers, adder, downstream writer)
    modport slave (
        output start_i, add_valid_i, add_sum_i, wr_ready_i,
        input  busy_o, done_o, rd_en_o, rd_addr_o, add_valid_o,
               wr_en_o, wr_addr_o, wr_data_o, wr_mask_o, err_o
    );
endinterface

// File: rtl/delta_tile_sched.sv
// Tile sequencer for the lane-parallel FP16 dt + dt_bias adder array.
// Issues NT = ceil(NH/H_TILE) tile reads, tracks the fixed-latency adder with
// credits so the internal result FIFO (depth A_LAT+2) can never overflow, and
// drains results to the write port under ready back-pressure.
// Optional protocol checker: define DELTA_SCHED_CHECK_EN to enable err_o.
module delta_tile_sched #(
    parameter int DW     = 16,
    parameter int H_TILE = 4,
    parameter int NH     = 24,
    parameter int A_LAT  = 11,
    parameter int AW     = 8
) (
    input logic               clk,
    input logic               rstn,
    delta_tile_sched_if.master bus
);
    localparam int NT = (NH + H_TILE - 1) / H_TILE;
    localparam int FD = A_LAT + 2;
    localparam int CW = $clog2(FD + 1);
    localparam int PW = $clog2(FD);
    localparam int EW = H_TILE * DW + AW;

    typedef enum logic [1:0] {IDLE, RUN, DRAIN, DONE} state_t;

    state_t          state, state_nxt;
    logic [AW-1:0]   rd_ptr, ret_ptr, wr_ptr;
    logic [CW-1:0]   in_flight, fifo_cnt;
    logic [CW:0]     occ;
    logic [PW-1:0]   head, tail;
    logic [EW-1:0]   mem [FD];
    logic [EW-1:0]   head_ent;
    logic            issue, ret, pop, fifo_empty, start_acc, add_vld_q;

    // Returns arriving with nothing outstanding are leftovers of an aborted
    // sweep and are dropped rather than counted.
    assign ret        = bus.add_valid_i && (in_flight != '0);
    assign fifo_empty = (fifo_cnt == '0);
    assign pop        = !fifo_empty && bus.wr_ready_i;
    assign occ        = {1'b0, in_flight} + {1'b0, fifo_cnt};
    assign start_acc  = (state == IDLE) && bus.start_i;

    // State register
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) state <= IDLE;
        else       state <= state_nxt;
    end

    // Next-state logic
    always_comb begin
        state_nxt = state;
        case (state)
            IDLE:  if (bus.start_i) state_nxt = RUN;
            RUN:   if (issue && rd_ptr == AW'(NT - 1)) state_nxt = DRAIN;
            DRAIN: if (pop && wr_ptr == AW'(NT - 1)) state_nxt = DONE;
            DONE:  state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    // FSM outputs; issue only while a FIFO slot is guaranteed for the result
    always_comb begin
        issue      = (state == RUN) && (occ < (CW + 1)'(FD));
        bus.busy_o = (state == RUN) || (state == DRAIN);
        bus.done_o = (state == DONE);
    end

    // Tile pointers and outstanding-adder count
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            rd_ptr    <= '0;
            ret_ptr   <= '0;
            wr_ptr    <= '0;
            in_flight <= '0;
            add_vld_q <= 1'b0;
        end else begin
            add_vld_q <= issue;
            if (start_acc) begin
                rd_ptr  <= '0;
                ret_ptr <= '0;
                wr_ptr  <= '0;
            end else begin
                if (issue) rd_ptr  <= rd_ptr + 1'b1;
                if (ret)   ret_ptr <= ret_ptr + 1'b1;
                if (pop)   wr_ptr  <= wr_ptr + 1'b1;
            end
            case ({issue, ret})
                2'b10:   in_flight <= in_flight + 1'b1;
                2'b01:   in_flight <= in_flight - 1'b1;
                default: in_flight <= in_flight;
            endcase
        end
    end

    // Result FIFO pointers and occupancy; push and pop may coincide
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            head     <= '0;
            tail     <= '0;
            fifo_cnt <= '0;
        end else begin
            if (ret) tail <= (tail == PW'(FD - 1)) ? '0 : tail + 1'b1;
            if (pop) head <= (head == PW'(FD - 1)) ? '0 : head + 1'b1;
            case ({ret, pop})
                2'b10:   fifo_cnt <= fifo_cnt + 1'b1;
                2'b01:   fifo_cnt <= fifo_cnt - 1'b1;
                default: fifo_cnt <= fifo_cnt;
            endcase
        end
    end

    // FIFO storage; contents are only observed through the non-empty gate
    always_ff @(posedge clk) begin
        if (ret) mem[tail] <= {ret_ptr, bus.add_sum_i};
    end

    assign head_ent        = fifo_empty ? '0 : mem[head];
    assign bus.wr_en_o     = !fifo_empty;
    assign bus.wr_addr_o   = head_ent[EW-1 -: AW];
    assign bus.wr_data_o   = head_ent[H_TILE*DW-1:0];
    assign bus.rd_en_o     = issue;
    assign bus.rd_addr_o   = rd_ptr;
    assign bus.add_valid_o = add_vld_q;

    // Lane mask: only the ragged last tile has lanes beyond NH switched off
    always_comb begin
        bus.wr_mask_o = '0;
        for (int k = 0; k < H_TILE; k++)
            bus.wr_mask_o[k] = !fifo_empty && (int'(bus.wr_addr_o) * H_TILE + k < NH);
    end

`ifdef DELTA_SCHED_CHECK_EN
    logic [A_LAT:1] shadow;
    logic           err_q;

    // Shadow of add_valid_o predicting each return slot; sticky error flag
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            shadow <= '0;
            err_q  <= 1'b0;
        end else begin
            shadow <= (shadow << 1) | A_LAT'(add_vld_q);
            if ((bus.add_valid_i != shadow[A_LAT]) ||
                (bus.add_valid_i && in_flight == '0) ||
                (ret && fifo_cnt == CW'(FD) && !pop))
                err_q <= 1'b1;
        end
    end
    assign bus.err_o = err_q;
`else
    assign bus.err_o = 1'b0;
`endif
endmodule

// File: tb/tb_delta_tile_sched.sv
// Bench for delta_tile_sched: three instances (NH = 24, 64, 22) each with a
// behavioural dt/bias buffer and an 11-cycle adder; expected tiles are queued
// at sweep start and popped as the write port accepts them.
module tb_delta_tile_sched;
    localparam int A_LAT = 11;
    localparam int FD    = A_LAT + 2;

    logic clk = 1'b0;
    logic rstn = 1'b0;
    logic lat12 = 1'b0;
    always #5 clk = ~clk;

    logic        start [3];
    logic        ready [3];
    logic        busy [3], done [3], rd_en [3], wr_en [3], err [3], addv [3];
    logic [7:0]  rd_addr [3], wr_addr [3];
    logic [63:0] wr_data [3];
    logic [3:0]  wr_mask [3];

    int passed = 0;
    int total  = 0;

    typedef struct packed {
        logic [7:0]  addr;
        logic [63:0] data;
        logic [3:0]  mask;
    } exp_t;
    exp_t exp_q[$];

    function automatic logic [63:0] sum_of(int g, int a);
        logic [63:0] r;
        for (int k = 0; k < 4; k++)
            r[k*16 +: 16] = 16'((g << 12) + (a << 4) + k) ^ 16'h5a00;
        return r;
    endfunction

    function automatic int nh_of(int g);
        return (g == 0) ? 24 : (g == 1) ? 64 : 22;
    endfunction

    for (genvar g = 0; g < 3; g++) begin : g_dut
        localparam int NHG = (g == 0) ? 24 : (g == 1) ? 64 : 22;
        delta_tile_sched_if #(.DW(16), .H_TILE(4), .AW(8)) bus ();
        delta_tile_sched #(.DW(16), .H_TILE(4), .NH(NHG), .A_LAT(A_LAT), .AW(8)) dut (
            .clk(clk), .rstn(rstn), .bus(bus)
        );
        logic [63:0] bufd;
        logic [12:1] v = '0;
        logic [63:0] s [1:12];

        assign bus.start_i     = start[g];
        assign bus.wr_ready_i  = ready[g];
        assign bus.add_valid_i = lat12 ? v[12] : v[A_LAT];
        assign bus.add_sum_i   = lat12 ? s[12] : s[A_LAT];
        assign busy[g]    = bus.busy_o;
        assign done[g]    = bus.done_o;
        assign rd_en[g]   = bus.rd_en_o;
        assign rd_addr[g] = bus.rd_addr_o;
        assign wr_en[g]   = bus.wr_en_o;
        assign wr_addr[g] = bus.wr_addr_o;
        assign wr_data[g] = bus.wr_data_o;
        assign wr_mask[g] = bus.wr_mask_o;
        assign err[g]     = bus.err_o;
        assign addv[g]    = bus.add_valid_o;

        // Buffer read (data the cycle after rd_en) feeding a free-running adder pipe
        always @(posedge clk) begin
            if (bus.rd_en_o) bufd <= sum_of(g, int'(bus.rd_addr_o));
            v    <= {v[11:1], bus.add_valid_o};
            s[1] <= bufd;
            for (int i = 2; i <= 12; i++) s[i] <= s[i-1];
        end
    end

    task automatic push_exp(input int sel);
        int nh, nt;
        exp_t e;
        nh = nh_of(sel);
        nt = (nh + 3) / 4;
        exp_q.delete();
        for (int t = 0; t < nt; t++) begin
            e.addr = 8'(t);
            e.data = sum_of(sel, t);
            for (int k = 0; k < 4; k++) e.mask[k] = (t * 4 + k < nh);
            exp_q.push_back(e);
        end
    endtask

    task automatic pulse_start(input int sel);
        @(posedge clk); #1 start[sel] = 1'b1;
        @(posedge clk); #1 start[sel] = 1'b0;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        for (int g = 0; g < 3; g++) begin
            total++;
            if ({busy[g], done[g], rd_en[g], wr_en[g], err[g], addv[g], wr_data[g], wr_mask[g]} !== '0)
                $display("FAIL reset_outputs[%0d]: got busy=%b done=%b rd=%b wr=%b err=%b data=%h mask=%b, expected all 0",
                         g, busy[g], done[g], rd_en[g], wr_en[g], err[g], wr_data[g], wr_mask[g]);
            else passed++;
        end
        @(posedge clk); #1 rstn = 1'b1;
    endtask

    task automatic test_sweep();
        int nrd = 0, nwr = 0, first_rd = -1, first_wr = -1, last_wr = -1, done_c = -1;
        logic busy_at_done = 1'b1;
        exp_t e, got;
        push_exp(0);
        ready[0] = 1'b1;
        pulse_start(0);
        for (int c = 0; c < 200 && done_c < 0; c++) begin
            @(negedge clk);
            if (rd_en[0]) begin
                if (first_rd < 0) first_rd = c;
                total++;
                if (rd_addr[0] !== 8'(nrd) || c != first_rd + nrd)
                    $display("FAIL sweep_rd: got addr=%0d at cycle %0d, expected addr=%0d at cycle %0d",
                             rd_addr[0], c, nrd, first_rd + nrd);
                else passed++;
                nrd++;
            end
            if (wr_en[0] && ready[0]) begin
                if (first_wr < 0) first_wr = c;
                last_wr = c;
                got = '{wr_addr[0], wr_data[0], wr_mask[0]};
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                total++;
                if (got !== e)
                    $display("FAIL sweep_wr: got addr=%0d data=%h mask=%b, expected addr=%0d data=%h mask=%b",
                             got.addr, got.data, got.mask, e.addr, e.data, e.mask);
                else passed++;
                nwr++;
            end
            if (done[0]) begin
                done_c = c;
                busy_at_done = busy[0];
            end
        end
        total++;
        if (nrd != 6) $display("FAIL sweep_rd_count: got %0d, expected 6", nrd); else passed++;
        total++;
        if (first_wr - first_rd != FD)
            $display("FAIL sweep_first_wr_latency: got %0d, expected %0d", first_wr - first_rd, FD);
        else passed++;
        total++;
        if (nwr != 6) $display("FAIL sweep_wr_count: got %0d, expected 6", nwr); else passed++;
        total++;
        if (done_c < 0 || done_c != last_wr + 1)
            $display("FAIL sweep_done_timing: got cycle %0d, expected %0d", done_c, last_wr + 1);
        else passed++;
        total++;
        if (busy_at_done !== 1'b0) $display("FAIL sweep_busy_at_done: got %b, expected 0", busy_at_done);
        else passed++;
    endtask

    task automatic test_full_stall();
        int nrd = 0, nwr = 0;
        logic seen_done = 1'b0;
        exp_t e, got;
        push_exp(1);
        ready[1] = 1'b0;
        pulse_start(1);
        for (int c = 0; c < 60; c++) begin
            @(negedge clk);
            if (rd_en[1]) nrd++;
        end
        total++;
        if (nrd != FD) $display("FAIL stall_issue_count: got %0d, expected %0d", nrd, FD); else passed++;
        total++;
        if (wr_en[1] !== 1'b1 || wr_addr[1] !== 8'd0)
            $display("FAIL stall_head: got wr_en=%b addr=%0d, expected wr_en=1 addr=0", wr_en[1], wr_addr[1]);
        else passed++;
        @(posedge clk); #1 ready[1] = 1'b1;
        for (int c = 0; c < 150 && !seen_done; c++) begin
            @(negedge clk);
            if (rd_en[1]) nrd++;
            if (wr_en[1] && ready[1]) begin
                got = '{wr_addr[1], wr_data[1], wr_mask[1]};
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                total++;
                if (got !== e)
                    $display("FAIL stall_wr: got addr=%0d data=%h mask=%b, expected addr=%0d data=%h mask=%b",
                             got.addr, got.data, got.mask, e.addr, e.data, e.mask);
                else passed++;
                nwr++;
            end
            if (done[1]) seen_done = 1'b1;
        end
        total++;
        if (nwr != 16 || nrd != 16 || !seen_done)
            $display("FAIL stall_complete: got writes=%0d reads=%0d done=%b, expected 16 16 1", nwr, nrd, seen_done);
        else passed++;
        total++;
        if (err[1] !== 1'b0) $display("FAIL stall_err: got %b, expected 0", err[1]); else passed++;
    endtask

    task automatic test_partial();
        int nwr = 0, n0011 = 0;
        logic seen_done = 1'b0;
        exp_t e, got;
        push_exp(2);
        ready[2] = 1'b1;
        pulse_start(2);
        for (int c = 0; c < 200 && !seen_done; c++) begin
            @(negedge clk);
            if (wr_en[2] && ready[2]) begin
                got = '{wr_addr[2], wr_data[2], wr_mask[2]};
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                total++;
                if (got !== e)
                    $display("FAIL partial_wr: got addr=%0d data=%h mask=%b, expected addr=%0d data=%h mask=%b",
                             got.addr, got.data, got.mask, e.addr, e.data, e.mask);
                else passed++;
                if (got.mask == 4'b0011) n0011++;
                nwr++;
            end
            if (done[2]) seen_done = 1'b1;
        end
        total++;
        if (nwr != 6 || n0011 != 1 || !seen_done)
            $display("FAIL partial_summary: got writes=%0d partial_masks=%0d done=%b, expected 6 1 1",
                     nwr, n0011, seen_done);
        else passed++;
    endtask

    task automatic test_toggle();
        int nwr = 0, stall_bad = 0, busy_bad = 0, nstall = 0;
        logic seen_done = 1'b0, prev_stall = 1'b0;
        logic [71:0] prev = '0;
        exp_t e, got;
        push_exp(0);
        ready[0] = 1'b0;
        pulse_start(0);
        for (int c = 0; c < 300 && !seen_done; c++) begin
            @(posedge clk); #1 ready[0] = ~ready[0];
            @(negedge clk);
            if (prev_stall && {wr_addr[0], wr_data[0]} !== prev) stall_bad++;
            prev_stall = wr_en[0] && !ready[0];
            prev = {wr_addr[0], wr_data[0]};
            if (prev_stall) nstall++;
            if (wr_en[0] && ready[0]) begin
                got = '{wr_addr[0], wr_data[0], wr_mask[0]};
                e = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
                total++;
                if (got !== e)
                    $display("FAIL toggle_wr: got addr=%0d data=%h mask=%b, expected addr=%0d data=%h mask=%b",
                             got.addr, got.data, got.mask, e.addr, e.data, e.mask);
                else passed++;
                nwr++;
            end
            if (done[0]) seen_done = 1'b1;
            else if (!busy[0]) busy_bad++;
        end
        total++;
        if (stall_bad != 0 || nstall == 0)
            $display("FAIL toggle_stable: got %0d unstable of %0d stalled cycles, expected 0 unstable", stall_bad, nstall);
        else passed++;
        total++;
        if (nwr != 6 || busy_bad != 0 || !seen_done)
            $display("FAIL toggle_summary: got writes=%0d busy_drops=%0d done=%b, expected 6 0 1", nwr, busy_bad, seen_done);
        else passed++;
        ready[0] = 1'b1;
    endtask

    task automatic test_reset_mid();
        logic any_done = 1'b0, any_wr = 1'b0;
        logic exp_err;
        exp_q.delete();
        ready[0] = 1'b1;
        pulse_start(0);
        repeat (5) @(negedge clk);
        @(posedge clk); #1 rstn = 1'b0;
        #1;
        total++;
        if ({busy[0], done[0], rd_en[0], wr_en[0], err[0], addv[0], wr_data[0], wr_mask[0]} !== '0)
            $display("FAIL midreset_outputs: got busy=%b rd=%b wr=%b addv=%b, expected all 0",
                     busy[0], rd_en[0], wr_en[0], addv[0]);
        else passed++;
        repeat (2) @(posedge clk);
        #1 rstn = 1'b1;
        for (int c = 0; c < 25; c++) begin
            @(negedge clk);
            any_done |= done[0];
            any_wr   |= wr_en[0];
        end
        total++;
        if (any_done || any_wr)
            $display("FAIL midreset_abort: got done=%b wr_en=%b, expected 0 0", any_done, any_wr);
        else passed++;
`ifdef DELTA_SCHED_CHECK_EN
        exp_err = 1'b1;
`else
        exp_err = 1'b0;
`endif
        total++;
        if (err[0] !== exp_err) $display("FAIL midreset_err: got %b, expected %b", err[0], exp_err);
        else passed++;
        test_sweep();
    endtask

`ifdef DELTA_SCHED_CHECK_EN
    task automatic test_checker();
        logic seen = 1'b0;
        @(posedge clk); #1 rstn = 1'b0;
        @(posedge clk); #1 rstn = 1'b1;
        @(negedge clk);
        total++;
        if (err[0] !== 1'b0) $display("FAIL checker_clear: got %b, expected 0", err[0]); else passed++;
        lat12 = 1'b1;
        pulse_start(0);
        for (int c = 0; c < 40 && !seen; c++) begin
            @(negedge clk);
            seen = err[0];
        end
        total++;
        if (!seen) $display("FAIL checker_detect: got err=0, expected 1"); else passed++;
        repeat (30) @(negedge clk);
        total++;
        if (err[0] !== 1'b1) $display("FAIL checker_sticky: got %b, expected 1", err[0]); else passed++;
        #1 rstn = 1'b0;
        #1;
        total++;
        if (err[0] !== 1'b0) $display("FAIL checker_reset: got %b, expected 0", err[0]); else passed++;
        @(posedge clk); #1 rstn = 1'b1;
        lat12 = 1'b0;
    endtask
`endif

    initial begin
        for (int g = 0; g < 3; g++) begin
            start[g] = 1'b0;
            ready[g] = 1'b0;
        end
        test_reset();
        test_sweep();
        test_full_stall();
        test_partial();
        test_toggle();
        test_reset_mid();
`ifdef DELTA_SCHED_CHECK_EN
        test_checker();
`endif
        repeat (5) @(posedge clk);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end
endmodule
